// File: rtl/mips_rf_pkg.sv
// Shared register-file types and constants for the write-back arbiter slice.
package mips_rf_pkg;
    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_AW-1:0] regAddr_t;
    typedef logic [DATA_W-1:0] regData_t;

    function automatic logic isZeroReg(input regAddr_t addr);
        return addr == REG_ZERO;
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Tracks registers reserved by the long-latency unit and flags decode hazards.
module rf_scoreboard
    import mips_rf_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     setEn,
    input  regAddr_t setAddr,
    input  logic     clrEn,
    input  regAddr_t clrAddr,
    input  regAddr_t decRs,
    input  regAddr_t decRt,
    input  regAddr_t decRd,
    input  logic     decWr,
    output logic     haz,
    output logic     sbErr
);
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] setMask;
    logic [NUM_REGS-1:0] clrMask;
    logic                setValid;

    assign setValid = setEn && !isZeroReg(setAddr);

    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (setValid) setMask[setAddr] = 1'b1;
        if (clrEn)    clrMask[clrAddr] = 1'b1;
    end

    // Set is applied after clear so a same-cycle re-issue keeps the register reserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            sbErr <= 1'b0;
        end else begin
            busy <= ((busy & ~clrMask) | setMask) & ~NUM_REGS'(1);
            if (setValid && busy[setAddr]) sbErr <= 1'b1;
        end
    end

    assign haz = busy[decRs] | busy[decRt] | (decWr & busy[decRd]);
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: WB-over-LU arbitration, registered write,
// LU starvation detection and decode stall generation.
module rf_wb_arbiter
    import mips_rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              wb_wr_en,
    input  logic [REG_AW-1:0] wb_wr_addr,
    input  logic [DATA_W-1:0] wb_wr_data,
    input  logic              lu_issue,
    input  logic [REG_AW-1:0] lu_issue_addr,
    input  logic              lu_wb_valid,
    input  logic [REG_AW-1:0] lu_wb_addr,
    input  logic [DATA_W-1:0] lu_wb_data,
    output logic              lu_wb_ready,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_wr,
    output logic              pipe_stall,
    output logic              rf_wr_en,
    output logic [REG_AW-1:0] rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              sb_err
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             wbSel;
    logic             luXfer;
    logic             luWrite;
    logic             luBlocked;
    logic             haz;
    logic             starve;
    logic [CNT_W-1:0] starveCnt;
    logic             luCommit_p1;

    assign wbSel       = wb_wr_en && !isZeroReg(wb_wr_addr);
    assign lu_wb_ready = i_rst_n && !wbSel;
    assign luXfer      = lu_wb_valid && lu_wb_ready;
    assign luWrite     = luXfer && !isZeroReg(lu_wb_addr);
    assign luBlocked   = lu_wb_valid && !lu_wb_ready;
    assign pipe_stall  = i_rst_n && (haz || starve);

    // ---- stage p1: registered RegFile write, committed by RegFile at end of this cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rf_wr_en    <= 1'b0;
            rf_wr_addr  <= '0;
            rf_wr_data  <= '0;
            luCommit_p1 <= 1'b0;
        end else begin
            rf_wr_en    <= wbSel || luWrite;
            luCommit_p1 <= !wbSel && luWrite;
            if (wbSel) begin
                rf_wr_addr <= wb_wr_addr;
                rf_wr_data <= wb_wr_data;
            end else if (luWrite) begin
                rf_wr_addr <= lu_wb_addr;
                rf_wr_data <= lu_wb_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starveCnt <= '0;
            starve    <= 1'b0;
        end else if (luXfer) begin
            starveCnt <= '0;
            starve    <= 1'b0;
        end else begin
            if (luBlocked && starveCnt != '1) starveCnt <= starveCnt + 1'b1;
            if (starveCnt == LIMIT) starve <= 1'b1;
        end
    end

    // Busy clears only once the LU write is on rf_* (the RegFile commit edge).
    rf_scoreboard uScoreboard (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .setEn   (lu_issue),
        .setAddr (lu_issue_addr),
        .clrEn   (luCommit_p1),
        .clrAddr (rf_wr_addr),
        .decRs   (dec_rs),
        .decRt   (dec_rt),
        .decRd   (dec_rd),
        .decWr   (dec_wr),
        .haz     (haz),
        .sbErr   (sb_err)
    );
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rstN;
    logic        wbWrEn;
    logic [4:0]  wbWrAddr;
    logic [31:0] wbWrData;
    logic        luIssue;
    logic [4:0]  luIssueAddr;
    logic        luWbValid;
    logic [4:0]  luWbAddr;
    logic [31:0] luWbData;
    logic        luWbReady;
    logic [4:0]  decRs, decRt, decRd;
    logic        decWr;
    logic        pipeStall;
    logic        rfWrEn;
    logic [4:0]  rfWrAddr;
    logic [31:0] rfWrData;
    logic        sbErr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .wb_wr_en      (wbWrEn),
        .wb_wr_addr    (wbWrAddr),
        .wb_wr_data    (wbWrData),
        .lu_issue      (luIssue),
        .lu_issue_addr (luIssueAddr),
        .lu_wb_valid   (luWbValid),
        .lu_wb_addr    (luWbAddr),
        .lu_wb_data    (luWbData),
        .lu_wb_ready   (luWbReady),
        .dec_rs        (decRs),
        .dec_rt        (decRt),
        .dec_rd        (decRd),
        .dec_wr        (decWr),
        .pipe_stall    (pipeStall),
        .rf_wr_en      (rfWrEn),
        .rf_wr_addr    (rfWrAddr),
        .rf_wr_data    (rfWrData),
        .sb_err        (sbErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_en"},    32'(rfWrEn),    32'd0);
        chk({tag, "_addr"},  32'(rfWrAddr),  32'd0);
        chk({tag, "_data"},  rfWrData,       32'd0);
        chk({tag, "_err"},   32'(sbErr),     32'd0);
        chk({tag, "_rdy"},   32'(luWbReady), 32'd0);
        chk({tag, "_stall"}, 32'(pipeStall), 32'd0);
    endtask

    initial begin
        rstN = 1'b0; wbWrEn = 0; wbWrAddr = 0; wbWrData = 0;
        luIssue = 0; luIssueAddr = 0; luWbValid = 0; luWbAddr = 0; luWbData = 0;
        decRs = 0; decRt = 0; decRd = 0; decWr = 0;
        step(); step();
        chkReset("rst");
        rstN = 1'b1;
        step();

        // 1: single WB write, one-cycle latency
        wbWrEn = 1; wbWrAddr = 5; wbWrData = 32'hDEAD_BEEF;
        #1 chk("t1_rdy_low", 32'(luWbReady), 32'd0);
        step();
        chk("t1_en",   32'(rfWrEn),   32'd1);
        chk("t1_addr", 32'(rfWrAddr), 32'd5);
        chk("t1_data", rfWrData,      32'hDEAD_BEEF);
        wbWrEn = 0;
        step();
        chk("t1_idle_en",   32'(rfWrEn),   32'd0);
        chk("t1_hold_addr", 32'(rfWrAddr), 32'd5);
        chk("t1_hold_data", rfWrData,      32'hDEAD_BEEF);

        // 2: WB beats LU, LU goes next idle cycle
        wbWrEn = 1; wbWrAddr = 7; wbWrData = 32'h0000_0077;
        luWbValid = 1; luWbAddr = 9; luWbData = 32'h0000_0099;
        #1 chk("t2_rdy_low", 32'(luWbReady), 32'd0);
        step();
        chk("t2_wb_addr", 32'(rfWrAddr), 32'd7);
        chk("t2_wb_data", rfWrData,      32'h0000_0077);
        wbWrEn = 0;
        #1 chk("t2_rdy_high", 32'(luWbReady), 32'd1);
        step();
        luWbValid = 0;
        chk("t2_lu_en",   32'(rfWrEn),   32'd1);
        chk("t2_lu_addr", 32'(rfWrAddr), 32'd9);
        chk("t2_lu_data", rfWrData,      32'h0000_0099);

        // 3: scoreboard hazard on reg 12
        luIssue = 1; luIssueAddr = 12;
        step();
        luIssue = 0;
        decRs = 12;
        #1 chk("t3_rs", 32'(pipeStall), 32'd1);
        decRs = 0; decRt = 12;
        #1 chk("t3_rt", 32'(pipeStall), 32'd1);
        decRt = 0; decRd = 12; decWr = 0;
        #1 chk("t3_rd_nowr", 32'(pipeStall), 32'd0);
        decWr = 1;
        #1 chk("t3_rd_wr", 32'(pipeStall), 32'd1);
        decWr = 0; decRd = 0;
        #1 chk("t3_r0", 32'(pipeStall), 32'd0);
        decRs = 12;
        luWbValid = 1; luWbAddr = 12; luWbData = 32'h0000_0C0C;
        #1 chk("t3_rdy", 32'(luWbReady), 32'd1);
        step();
        luWbValid = 0;
        chk("t3_commit_en",   32'(rfWrEn),    32'd1);
        chk("t3_commit_addr", 32'(rfWrAddr),  32'd12);
        chk("t3_stall_commit", 32'(pipeStall), 32'd1);
        step();
        chk("t3_stall_clear", 32'(pipeStall), 32'd0);
        decRs = 0;

        // 4: starvation under continuous WB
        wbWrEn = 1; wbWrAddr = 1; wbWrData = 32'h1111_1111;
        luWbValid = 1; luWbAddr = 20; luWbData = 32'h2020_2020;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("t4_starve_%0d", i), 32'(pipeStall), (i >= 9) ? 32'd1 : 32'd0);
        end
        wbWrEn = 0;
        #1 chk("t4_rdy", 32'(luWbReady), 32'd1);
        chk("t4_stall_held", 32'(pipeStall), 32'd1);
        step();
        chk("t4_clear", 32'(pipeStall), 32'd0);
        chk("t4_lu_addr", 32'(rfWrAddr), 32'd20);
        chk("t4_lu_data", rfWrData,      32'h2020_2020);
        wbWrEn = 1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("t4_recount_%0d", i), 32'(pipeStall), (i >= 9) ? 32'd1 : 32'd0);
        end
        wbWrEn = 0;
        step();
        luWbValid = 0;
        chk("t4_clear2", 32'(pipeStall), 32'd0);

        // 5: double issue error, LU write to $0
        luIssue = 1; luIssueAddr = 3;
        step();
        chk("t5_err_first", 32'(sbErr), 32'd0);
        step();
        luIssue = 0;
        chk("t5_err_set", 32'(sbErr), 32'd1);
        step();
        chk("t5_err_sticky", 32'(sbErr), 32'd1);
        luWbValid = 1; luWbAddr = 0; luWbData = 32'h0000_0005;
        #1 chk("t5_r0_rdy", 32'(luWbReady), 32'd1);
        step();
        luWbValid = 0;
        chk("t5_r0_en",   32'(rfWrEn),   32'd0);
        chk("t5_r0_addr", 32'(rfWrAddr), 32'd20);

        // 6: asynchronous reset with busy reg and pending write
        luIssue = 1; luIssueAddr = 4;
        step();
        luIssue = 0;
        decRs = 4;
        #1 chk("t6_busy", 32'(pipeStall), 32'd1);
        wbWrEn = 1; wbWrAddr = 6; wbWrData = 32'h6666_6666;
        step();
        chk("t6_pending", 32'(rfWrEn), 32'd1);
        wbWrEn = 0;
        #2 rstN = 1'b0;
        #1 chkReset("t6_async");
        step();
        rstN = 1'b1;
        #1 chk("t6_busy_cleared", 32'(pipeStall), 32'd0);
        chk("t6_err_cleared", 32'(sbErr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
